// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the parametrised synchronous FIFO
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// rtl/fifo_mem_1r1w.sv - FIFO storage array, synchronous write port, asynchronous read port
module fifo_mem_1r1w #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 10,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with occupancy, level flags, sticky errors and FWFT mode
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 10,
  parameter int AF_LEVEL = 8,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int         CW   = cnt_w(DEPTH);
  localparam int         AW   = $clog2(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH must be >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("sync_fifo_param: AF_LEVEL must be in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_param: AE_LEVEL must be in 0..DEPTH-1");
    end
  endgenerate

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mem_rdata;
  logic [WIDTH-1:0] rd_q;
  logic             rd_valid_q;
  logic             wr_acc;
  logic             rd_acc;
  logic             flush;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags come only from the registered count, never from this cycle's requests.
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;
  assign flush  = rst | clr;

  fifo_mem_1r1w #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc & ~flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      rd_valid_q <= rd_acc;
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

  // In FWFT mode rd_q tracks the visible head so rd_data holds its last value once empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (MODE == FIFO_FWFT) begin
      if (!empty) rd_q <= mem_rdata;
    end else if (rd_acc && !clr) begin
      rd_q <= mem_rdata;
    end
  end

  assign rd_data  = (MODE == FIFO_FWFT && !empty) ? mem_rdata : rd_q;
  assign rd_valid = (MODE == FIFO_FWFT) ? ~empty : rd_valid_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench, registered and FWFT instances side by side
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst, clr, wr_en, rd_en;
  logic [7:0] wr_data;

  logic [7:0] rd_data_s, rd_data_f;
  logic       rd_valid_s, rd_valid_f;
  logic       full_s, empty_s, af_s, ae_s, ov_s, uf_s;
  logic       full_f, empty_f, af_f, ae_f, ov_f, uf_f;
  logic [3:0] count_s, count_f;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(8), .DEPTH(10), .AF_LEVEL(8), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_s), .rd_valid(rd_valid_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
    .overflow(ov_s), .underflow(uf_s)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(10), .AF_LEVEL(8), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data_f), .rd_valid(rd_valid_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overflow(ov_f), .underflow(uf_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One cycle with an optional write and an optional read of a word known to be present.
  task automatic xfer(input logic w, input logic [7:0] wd, input logic r, input logic [7:0] exp);
    wr_en = w; wr_data = wd; rd_en = r;
    #1;
    if (r) check("fwft_head", rd_data_f, exp);
    step();
    if (r) begin
      check("std_rd_valid", rd_valid_s, 1);
      check("std_rd_data", rd_data_s, exp);
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    step(); step();
    rst = 1'b0;
    check("rst_count", count_s, 0);
    check("rst_empty", empty_s, 1);
    check("rst_ae", ae_s, 1);
    check("rst_full", full_s, 0);
    check("rst_af", af_s, 0);
    check("rst_flags", {ov_s, uf_s, ov_f, uf_f}, 0);
    check("rst_rd_data_s", rd_data_s, 0);
    check("rst_rd_data_f", rd_data_f, 0);
    check("rst_rd_valid", {rd_valid_s, rd_valid_f}, 0);

    // fill 0x11..0x1A
    for (int i = 0; i < 10; i++) begin
      xfer(1'b1, 8'(8'h11 + i), 1'b0, 8'h00);
      check("fill_count", count_s, i + 1);
      check("fill_af", af_s, (i + 1 >= 8) ? 1 : 0);
      check("fill_full", full_s, (i + 1 == 10) ? 1 : 0);
    end
    check("fill_fwft_head", rd_data_f, 8'h11);
    check("fill_fwft_valid", rd_valid_f, 1);
    xfer(1'b1, 8'hFF, 1'b0, 8'h00);
    check("ovf_flag", ov_s, 1);
    check("ovf_flag_f", ov_f, 1);
    check("ovf_count", count_s, 10);

    // drain in order
    for (int i = 0; i < 10; i++) xfer(1'b0, 8'h00, 1'b1, 8'(8'h11 + i));
    check("drain_empty", empty_s, 1);
    check("drain_empty_f", empty_f, 1);
    check("drain_uf_pre", uf_s, 0);
    rd_en = 1'b1; step(); rd_en = 1'b0;
    check("udf_flag", uf_s, 1);
    check("udf_flag_f", uf_f, 1);
    check("udf_rd_valid", rd_valid_s, 0);
    check("udf_rd_valid_f", rd_valid_f, 0);
    check("udf_hold_s", rd_data_s, 8'h1A);
    check("udf_hold_f", rd_data_f, 8'h1A);

    // wrap: pointers move to 7, then hold count=3 across the 9->0 boundary
    for (int i = 0; i < 7; i++) xfer(1'b1, 8'(8'h20 + i), 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) xfer(1'b0, 8'h00, 1'b1, 8'(8'h20 + i));
    for (int i = 0; i < 3; i++) xfer(1'b1, 8'(8'h30 + i), 1'b0, 8'h00);
    check("wrap_count_pre", count_s, 3);
    for (int i = 0; i < 20; i++) begin
      xfer(1'b1, 8'(8'h33 + i), 1'b1, 8'(8'h30 + i));
      check("wrap_count", count_s, 3);
    end
    for (int i = 0; i < 3; i++) xfer(1'b0, 8'h00, 1'b1, 8'(8'h44 + i));
    check("wrap_empty", empty_s, 1);

    // simultaneous wr+rd at full, then at empty
    clr = 1'b1; step(); clr = 1'b0;
    check("clr1_flags", {ov_s, uf_s}, 0);
    for (int i = 0; i < 10; i++) xfer(1'b1, 8'(8'h50 + i), 1'b0, 8'h00);
    check("full_before", full_s, 1);
    xfer(1'b1, 8'hEE, 1'b1, 8'h50);
    check("full_rw_count", count_s, 9);
    check("full_rw_ovf", ov_s, 1);
    check("full_rw_full", full_s, 0);
    for (int i = 0; i < 9; i++) xfer(1'b0, 8'h00, 1'b1, 8'(8'h51 + i));
    check("full_rw_empty", empty_s, 1);
    wr_en = 1'b1; wr_data = 8'h77; rd_en = 1'b1; step(); wr_en = 1'b0; rd_en = 1'b0;
    check("empty_rw_count", count_s, 1);
    check("empty_rw_udf", uf_s, 1);
    check("empty_rw_valid", rd_valid_s, 0);
    check("empty_rw_fwft", rd_data_f, 8'h77);

    // clr with count=5 and both sticky flags set
    for (int i = 0; i < 4; i++) xfer(1'b1, 8'(8'h78 + i), 1'b0, 8'h00);
    check("pre_clr_count", count_s, 5);
    clr = 1'b1; step(); clr = 1'b0;
    check("clr_count", count_s, 0);
    check("clr_count_f", count_f, 0);
    check("clr_empty", empty_s, 1);
    check("clr_ae", ae_s, 1);
    check("clr_flags", {ov_s, uf_s, ov_f, uf_f}, 0);
    check("clr_hold_s", rd_data_s, 8'h59);
    check("clr_hold_f", rd_data_f, 8'h77);
    xfer(1'b1, 8'hA5, 1'b0, 8'h00);
    xfer(1'b0, 8'h00, 1'b1, 8'hA5);
    check("post_clr_count", count_s, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
